// File: rtl/motor_pwm_decoder.sv
// -----------------------------------------------------------------------------
// motor_pwm_decoder
//
// Measures the motor PWM waveform and recovers the 12-bit drive code that the
// PWM generator used (generator: high time = code + Offset, period 6826).
// Reports the last high time, the last rise-to-rise period, a one-cycle Valid
// strobe per measured period, and a Timeout level for a stuck-high or
// stuck-low line.
//
// Optional feature: define PWM_DEGLITCH_EN to insert a level filter between
// the synchronizer and the edge detector. With the filter, the level changes
// only after DeglitchCycles consecutive differing samples. Without the macro
// there is no filter logic.
//
// Ports:
//   PWMClock    in   1   50 MHz clock, rising edge
//   PWMReset_n  in   1   synchronous active-low reset
//   PWMin       in   1   asynchronous PWM line being measured
//   DutyOut     out  12  recovered code, sat(high time - Offset) to 0..4095
//   HighOut     out  13  last measured high time (clocks)
//   PeriodOut   out  13  last measured rise-to-rise period (clocks)
//   Valid       out  1   one-cycle strobe, outputs updated this cycle
//   Timeout     out  1   last event was a timeout; cleared by a good period
// -----------------------------------------------------------------------------
module motor_pwm_decoder #(
  parameter int Offset         = 2730,
  parameter int MaxPeriod      = 8191,
  parameter int DeglitchCycles = 3
) (
  input  logic        PWMClock,
  input  logic        PWMReset_n,
  input  logic        PWMin,
  output logic [11:0] DutyOut,
  output logic [12:0] HighOut,
  output logic [12:0] PeriodOut,
  output logic        Valid,
  output logic        Timeout
);

  if (Offset < 0 || Offset > 8191 || MaxPeriod < 2 || MaxPeriod > 8191 ||
      DeglitchCycles < 1 || DeglitchCycles > 15) begin : g_bad_param
    $error("motor_pwm_decoder: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, HIGH, LOW, STUCK_H, STUCK_L} state_e;

  localparam logic [12:0]        MaxCnt   = 13'(MaxPeriod);
  localparam logic signed [13:0] OffsetS  = 14'(Offset);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic level;
  logic rise, fall;

`ifdef PWM_DEGLITCH_EN
  logic       filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;

  // The filtered level flips only once the synchronized input has disagreed
  // with it for DeglitchCycles consecutive samples; any agreement restarts.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == 4'(DeglitchCycles - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge PWMClock) begin
    if (!PWMReset_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d = PWMin;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [12:0] cnt_q,   cnt_d;
  logic [12:0] hlat_q,  hlat_d;
  logic        hok_q,   hok_d;   // hlat_q belongs to the period now closing
  logic [11:0] duty_q,  duty_d;
  logic [12:0] high_q,  high_d;
  logic [12:0] per_q,   per_d;
  logic        valid_q, valid_d;
  logic        tmo_q,   tmo_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge PWMClock) begin
    if (!PWMReset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      hlat_q  <= '0;
      hok_q   <= 1'b0;
      duty_q  <= '0;
      high_q  <= '0;
      per_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hlat_q  <= hlat_d;
      hok_q   <= hok_d;
      duty_q  <= duty_d;
      high_q  <= high_d;
      per_q   <= per_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; an edge always wins over a simultaneous timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = HIGH;
      HIGH:    if (fall) state_d = LOW;
               else if (cnt_q == MaxCnt) state_d = STUCK_H;
      LOW:     if (rise) state_d = HIGH;
               else if (cnt_q == MaxCnt) state_d = STUCK_L;
      STUCK_H: if (fall) state_d = LOW;
      STUCK_L: if (rise) state_d = HIGH;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, latch and output-register logic
  // ---------------------------------------------------------------------------
  logic signed [13:0] duty_diff;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    duty_diff = $signed({1'b0, hlat_q}) - OffsetS;
    hlat_d    = hlat_q;
    hok_d     = hok_q;
    duty_d    = duty_q;
    high_d    = high_q;
    per_d     = per_q;
    valid_d   = 1'b0;
    tmo_d     = tmo_q;

    // Cnt = 1 on the cycle after a rise (or after leaving STUCK_H), so a fall
    // detect sees the high time and the next rise detect sees the period.
    if (rise || (state_q == STUCK_H && fall)) begin
      cnt_d = 13'd1;
    end else if (cnt_q == MaxCnt) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 13'd1;
    end

    unique case (state_q)
      HIGH: begin
        if (fall) begin
          hlat_d = cnt_q;
          hok_d  = 1'b1;
        end else if (cnt_q == MaxCnt) begin
          duty_d  = 12'd4095;
          high_d  = MaxCnt;
          per_d   = MaxCnt;
          tmo_d   = 1'b1;
          valid_d = 1'b1;
          hok_d   = 1'b0;   // the high time of this period is unknown
        end
      end
      LOW: begin
        if (rise) begin
          // The first rise after a stuck-high recovery closes a period whose
          // high time was never measured, so it only restarts measurement.
          if (hok_q) begin
            high_d  = hlat_q;
            per_d   = cnt_q;
            tmo_d   = 1'b0;
            valid_d = 1'b1;
            if (duty_diff <= 14'sd0) begin
              duty_d = '0;
            end else if (duty_diff > 14'sd4095) begin
              duty_d = 12'd4095;
            end else begin
              duty_d = duty_diff[11:0];
            end
          end
        end else if (cnt_q == MaxCnt) begin
          duty_d  = '0;
          high_d  = '0;
          per_d   = MaxCnt;
          tmo_d   = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign DutyOut   = duty_q;
  assign HighOut   = high_q;
  assign PeriodOut = per_q;
  assign Valid     = valid_q;
  assign Timeout   = tmo_q;

endmodule

// File: doc/motor_pwm_decoder.md
Name: motor_pwm_decoder

Overview:
- Measures an incoming motor PWM waveform and recovers the 12-bit drive code that produced it, so the control loop can read back what the motor controller sees.
- It inverts the motorPWMgenerator mapping, where high time = code + Offset and the period is 6826 clocks.
- It reports high time, period, a per-period valid strobe, and a timeout flag for stuck-high or stuck-low lines.
- It sits between the motor connector sense pin and the control/filter logic, in the PWMClock (50 MHz) domain.

Parameters:
- Offset, 2730, clocks of high time subtracted to recover the code; matches the generator.
- MaxPeriod, 8191, count at which a missing edge is declared a timeout; range 2..8191.
- DeglitchCycles, 3, consecutive equal samples required by the optional filter; range 1..15.

Ports:
- PWMClock  in  1  50 MHz system clock; all logic on the rising edge.
- PWMReset_n  in  1  synchronous, active-low reset.
- PWMin  in  1  asynchronous PWM line being measured.
- DutyOut  out  12  recovered code: high time minus Offset, saturated to 0..4095.
- HighOut  out  13  last measured high time, in clocks.
- PeriodOut  out  13  last measured rise-to-rise period, in clocks.
- Valid  out  1  one-cycle strobe; outputs updated this cycle.
- Timeout  out  1  level; set when the last event was a timeout, cleared by the next good period.

Behaviour:
- Reset: one clock, synchronous and active-low. While PWMReset_n=0 at a clock edge, all outputs go to 0, the synchronizer flops go to 0, the counter goes to 0, and the state goes to IDLE. Reset mid-period discards the partial measurement.
- Input conditioning: 2-flop synchronizer, then a prev register. Rise = sync & ~prev; Fall = ~sync & prev. Edge detection latency is 3 clocks from the PWMin transition.
- Counter Cnt, 13 bits:
  - Loaded with 1 on the cycle after a Rise.
  - Increments by 1 every cycle otherwise.
  - Saturates at MaxPeriod; it never wraps.
  - So the Fall detect cycle sees Cnt = H (high clocks), and the next Rise detect sees Cnt = P.
- States:
  - IDLE: wait for Rise, load Cnt, go to HIGH. No output on the first edge after reset or after a timeout.
  - HIGH:
    - Fall: latch Hlat = Cnt, go to LOW.
    - Cnt == MaxPeriod: stuck high. DutyOut=4095, HighOut=MaxPeriod, PeriodOut=MaxPeriod, Timeout=1, Valid=1 for one cycle, go to STUCK_H.
  - LOW:
    - Rise:
      - HighOut=Hlat, PeriodOut=Cnt.
      - DutyOut = sat(Hlat - Offset): 0 if Hlat <= Offset, 4095 if the difference exceeds 4095.
      - Timeout=0, Valid=1, reload Cnt, go to HIGH.
      - Outputs register on the clock after the Rise detect.
    - Cnt == MaxPeriod: stuck low. DutyOut=0, HighOut=0, PeriodOut=MaxPeriod, Timeout=1, Valid=1, go to STUCK_L.
  - STUCK_H: on Fall, go to LOW with Cnt reloaded to 1 and no Valid.
  - STUCK_L: on Rise, go to HIGH with Cnt reloaded and no Valid. Timeout stays 1 until the next normal Valid.
- Simultaneous events: Rise on the same cycle Cnt reaches MaxPeriod in LOW means the edge wins, so it is a normal measurement.
- Width rules: subtraction is done in 14-bit signed before saturation; Offset must be < 8192.
- Minimum measurable pulse: 1 clock high or low. With the filter enabled, the minimum is DeglitchCycles.

Optional Feature:
- Macro: PWM_DEGLITCH_EN.
- Defined:
  - A filter between the synchronizer and the edge detector.
  - The filtered level changes only after DeglitchCycles consecutive samples differ from it.
  - Shorter pulses are ignored entirely.
  - Adds DeglitchCycles clocks of latency to both edges; measured H and P are unchanged for clean input.
  - The filter's level and counter reset to 0.
- Undefined: the synchronizer output drives the edge detector directly; no filter logic is present.

Test Plan:
- Generator-shaped input, 3730 clocks high, 3096 low, repeated 3 periods -> first Valid is after the second rise; DutyOut=1000, HighOut=3730, PeriodOut=6826, Timeout=0 on each Valid.
- High 2000, period 6826 -> DutyOut=0, HighOut=2000. High 6825, period 6826 -> DutyOut=4095.
- PWMin held high 10000 clocks after one rise -> single Valid when Cnt reaches 8191, DutyOut=4095, Timeout=1. Then a 3000/3826 waveform -> no Valid on the first rise; the next full period gives DutyOut=270, Timeout=0.
- PWMin held low after a fall -> Valid with DutyOut=0, PeriodOut=8191, Timeout=1, with no further Valid until edges return.
- Assert PWMReset_n=0 for 1 clock mid-HIGH -> all outputs 0 next cycle; the first Valid after reset occurs only after one complete rise-to-rise period.
- With PWM_DEGLITCH_EN, 2-clock glitch low inside a 3730-clock high -> ignored, DutyOut=1000. Without the macro -> Valid with HighOut equal to the pre-glitch segment length.
